// File: rtl/counter_sequencer_pkg.sv
// Shared types and default sizes for the counter sequencer.
package counter_sequencer_pkg;

    localparam int unsigned CS_WIDTH    = 4;
    localparam int unsigned CS_PS_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : counter_sequencer_pkg

// File: rtl/counter_sequencer_tick_gen.sv
// Prescale divider: emits a one-cycle tick every div+1 enabled cycles.
module tick_gen
    import counter_sequencer_pkg::*;
#(
    parameter int unsigned PS_WIDTH = CS_PS_WIDTH
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                run,
    input  logic [PS_WIDTH-1:0] div,
    output logic                tick
);

    logic [PS_WIDTH-1:0] ps_q;
    logic [PS_WIDTH-1:0] ps_d;

    // Tick fires on the enabled cycle where the divider reaches its terminal value.
    assign tick = run && (ps_q == div);

    // Next divider value: clear wins, then wrap or advance while enabled, else freeze.
    always_comb begin
        ps_d = ps_q;
        if (clear) begin
            ps_d = '0;
        end else if (run) begin
            if (ps_q == div) begin
                ps_d = '0;
            end else begin
                ps_d = ps_q + PS_WIDTH'(1);
            end
        end
    end

    // Divider register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

endmodule : tick_gen

// File: rtl/counter_sequencer.sv
// Interval timer controller: start/stop FSM, prescaled up-counter, terminal compare, done pulse.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH    = CS_WIDTH,
    parameter int unsigned PS_WIDTH = CS_PS_WIDTH
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                stop,
    input  logic                periodic,
    input  logic [WIDTH-1:0]    limit,
    input  logic [PS_WIDTH-1:0] prescale,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    count
);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [WIDTH-1:0]    limit_q, limit_d;
    logic [PS_WIDTH-1:0] prescale_q, prescale_d;
    logic                periodic_q, periodic_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                ps_clear_c;
    logic                ps_run_c;
    logic                tick_c;

    // The divider freezes on the stop edge so ps holds its value in IDLE.
    assign ps_run_c = (state_q == RUN) && !stop;

    tick_gen #(
        .PS_WIDTH (PS_WIDTH)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (ps_clear_c),
        .run     (ps_run_c),
        .div     (prescale_q),
        .tick    (tick_c)
    );

    // Next state, count, configuration latch and done pulse.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        limit_d    = limit_q;
        prescale_d = prescale_q;
        periodic_d = periodic_q;
        done_d     = 1'b0;
        ps_clear_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    limit_d    = limit;
                    prescale_d = prescale;
                    periodic_d = periodic;
                    count_d    = '0;
                    ps_clear_c = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (tick_c) begin
                    if (count_q == limit_q) begin
                        done_d = 1'b1;
                        if (periodic_q) begin
                            count_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            limit_q    <= '0;
            prescale_q <= '0;
            periodic_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            limit_q    <= limit_d;
            prescale_q <= prescale_d;
            periodic_q <= periodic_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;

endmodule : counter_sequencer

// File: tb/tb_counter_sequencer.sv
// Directed self-checking bench for counter_sequencer.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       stop;
    logic       periodic;
    logic [3:0] limit;
    logic [7:0] prescale;
    logic       busy;
    logic       done;
    logic [3:0] count;

    int n_vec  = 0;
    int n_miss = 0;

    counter_sequencer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .limit    (limit),
        .prescale (prescale),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present configuration with start for exactly one edge (edge E0).
    task automatic go(input logic [3:0] lim, input logic [7:0] ps, input logic per);
        limit    = lim;
        prescale = ps;
        periodic = per;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic chk3(input string tag, input logic b, input logic d, input logic [3:0] c);
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".count"}, 32'(count), 32'(c));
    endtask

    // Periodic expectation table for limit=2, prescale=1: count after edges E1..E6.
    logic [3:0] per_cnt [6] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0};

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        periodic = 1'b0;
        limit    = 4'd0;
        prescale = 8'd0;

        // Reset held while start toggles.
        for (int i = 0; i < 4; i++) begin
            start = ~start;
            step();
            chk3("rst_hold", 1'b0, 1'b0, 4'd0);
        end
        start = 1'b0;
        #2 reset_n = 1'b1;
        #1 chk3("rst_release", 1'b0, 1'b0, 4'd0);
        step();
        chk3("rst_after", 1'b0, 1'b0, 4'd0);

        // start and stop together in IDLE: stop wins.
        stop = 1'b1;
        go(4'd3, 8'd0, 1'b0);
        stop = 1'b0;
        chk3("start_stop_idle", 1'b0, 1'b0, 4'd0);

        // One-shot basic.
        go(4'd3, 8'd0, 1'b0);
        chk3("os_e0", 1'b1, 1'b0, 4'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk3("os_cnt", 1'b1, 1'b0, 4'(i));
        end
        step();
        chk3("os_done", 1'b0, 1'b1, 4'd3);
        step();
        chk3("os_after", 1'b0, 1'b0, 4'd3);

        // Prescale 1, periodic, three periods.
        go(4'd2, 8'd1, 1'b1);
        chk3("per_e0", 1'b1, 1'b0, 4'd0);
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 6; k++) begin
                step();
                chk3("per", 1'b1, (k == 5), per_cnt[k]);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk3("per_stop", 1'b0, 1'b0, 4'd0);

        // Stop on the terminal tick suppresses done.
        go(4'd3, 8'd0, 1'b0);
        step(); step(); step();
        chk3("sp_at3", 1'b1, 1'b0, 4'd3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk3("sp_stopped", 1'b0, 1'b0, 4'd3);
        step();
        chk3("sp_idle", 1'b0, 1'b0, 4'd3);
        go(4'd3, 8'd0, 1'b0);
        chk3("sp_restart", 1'b1, 1'b0, 4'd0);
        step(); step(); step(); step();
        chk3("sp_redone", 1'b0, 1'b1, 4'd3);

        // Config changes and start during RUN are ignored.
        go(4'd5, 8'd0, 1'b0);
        step();
        limit = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk3("cfg_e2", 1'b1, 1'b0, 4'd2);
        step(); step(); step();
        chk3("cfg_e5", 1'b1, 1'b0, 4'd5);
        step();
        chk3("cfg_done", 1'b0, 1'b1, 4'd5);

        // limit=0 one-shot: done one cycle after start.
        go(4'd0, 8'd0, 1'b0);
        chk3("l0_e0", 1'b1, 1'b0, 4'd0);
        step();
        chk3("l0_done", 1'b0, 1'b1, 4'd0);
        step();
        chk3("l0_after", 1'b0, 1'b0, 4'd0);

        // limit=0, prescale=0, periodic: done continuously high.
        go(4'd0, 8'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk3("l0p", 1'b1, 1'b1, 4'd0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk3("l0p_stop", 1'b0, 1'b0, 4'd0);

        // Full-range limit: reaches 15 without wrap, done after 16 edges.
        go(4'd15, 8'd0, 1'b0);
        for (int i = 1; i <= 15; i++) step();
        chk3("l15_e15", 1'b1, 1'b0, 4'd15);
        step();
        chk3("l15_done", 1'b0, 1'b1, 4'd15);
        step();
        chk3("l15_after", 1'b0, 1'b0, 4'd15);

        // Asynchronous reset mid-run.
        go(4'd9, 8'd0, 1'b1);
        step(); step(); step();
        chk3("mr_pre", 1'b1, 1'b0, 4'd3);
        #2 reset_n = 1'b0;
        #1 chk3("mr_reset", 1'b0, 1'b0, 4'd0);
        step();
        #2 reset_n = 1'b1;
        step();
        chk3("mr_idle", 1'b0, 1'b0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_counter_sequencer

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Programmable interval-timer controller that sequences an up-counting datapath. Provides start/stop control, a prescaled count tick, terminal-count compare, one-shot or periodic mode, and a single-cycle done pulse.
- Sits between a control/config source (test logic or CPU-facing registers) and logic that consumes a timed event or the live count value.

Parameters:
- WIDTH, 4, width of count and limit.
- PS_WIDTH, 8, width of prescale divider.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  level, sampled each edge; starts a run from IDLE.
- stop  input  1  level, sampled each edge; aborts a run.
- periodic  input  1  mode: 0 one-shot, 1 auto-reload. Latched on start.
- limit  input  WIDTH  terminal count value. Latched on start.
- prescale  input  PS_WIDTH  tick divider P. One tick every P+1 cycles. Latched on start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse at terminal count.
- count  output  WIDTH  current count value.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, count=0, prescale counter ps=0, busy=0, done=0, all latched configuration cleared.
- States: IDLE and RUN. busy is 1 exactly when state=RUN. busy is registered and changes on the same edge as state.
- IDLE with start=1 and stop=0:
  - Latch limit, prescale and periodic.
  - count<=0, ps<=0, state<=RUN.
  - start with limit=0 is legal: done fires after P+1 cycles.
- RUN:
  - Each edge: if ps==P_q then tick, ps<=0; otherwise ps<=ps+1.
  - On a tick with count!=limit_q: count<=count+1.
  - On a tick with count==limit_q: done<=1 for one cycle.
    - periodic_q=1: count<=0 and remain in RUN.
    - periodic_q=0: state<=IDLE and count holds at limit_q.
- Timing: from the edge that samples start to the edge that raises done = (limit+1)*(prescale+1) cycles. Periodic mode repeats done at that interval with no gap cycles.
- stop=1 in RUN: state<=IDLE at the next edge, count and ps freeze, no done.
  - stop has priority over a simultaneous terminal tick, so no done is produced.
- start while in RUN is ignored; no restart and no re-latch.
- start and stop both high in IDLE: stop wins and the block stays IDLE.
- Input changes to limit, prescale or periodic during RUN have no effect until the next start.
- count never exceeds limit_q and never wraps past 2^WIDTH-1, because the compare precedes the increment. limit=2^WIDTH-1 is legal.
- done is registered, never asserted in IDLE except on the cycle immediately after the one-shot terminal edge, and never high for two consecutive cycles unless limit=0 and prescale=0 in periodic mode. In that case done is continuously high and each cycle counts as one event.
- Reset mid-run returns immediately to the reset values. Any pending done is lost.

Decomposition:
- Package counter_sequencer_pkg holds:
  - the state type, encoding IDLE=1'b0 and RUN=1'b1;
  - default WIDTH and PS_WIDTH constants.
- Sub-module tick_gen holds the prescale counter.
  - Inputs: clk, reset_n, clear, run, div.
  - Output: tick, a one-cycle pulse every div+1 enabled cycles.
  - Top level keeps the FSM, count, compare and done.

Test Plan:
- Reset: hold reset_n=0 while toggling start → busy=0, done=0, count=0. Release reset_n asynchronously mid-cycle → outputs remain 0.
- One-shot basic: limit=3, prescale=0, periodic=0, start pulse at edge E0 → count 1,2,3 after E1..E3; done=1 and busy=0 after E4; count holds at 3; done low after E5.
- Prescale and periodic: limit=2, prescale=1, periodic=1 → done pulses every 6 cycles for 3 periods; count sequence 0,0,1,1,2,2,0…; busy stays 1.
- Stop priority: limit=3, prescale=0; assert stop on the cycle count==3 (the terminal tick) → no done, busy=0, count=3. A subsequent start restarts from count=0.
- Config isolation: start with limit=5, then change limit to 1 and pulse start again mid-run → terminal at count=5 after 6 cycles; the second start is ignored.
- Edge limits: limit=0, prescale=0, one-shot → done exactly 1 cycle after start. limit=15 (WIDTH=4) → count reaches 15 with no wrap, and done after 16 cycles.
